// File: rtl/sum_arbiter_pkg.sv
// Shared definitions for the sum adder arbiter: FSM state encoding and the
// default datapath width used by sum, cbrt and the arbiter.
package sum_arbiter_pkg;

  // IDLE arbitrates every cycle; LOCKED keeps the adder with one owner.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Operand/result width shared with the sum and cbrt units.
  localparam int DEFAULT_WIDTH = 16;

endpackage : sum_arbiter_pkg

// File: rtl/sum_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: scans the request vector
// starting at ptr_i, wrapping around, and reports the first requester found.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  logic [PTR_W-1:0] cand;

  // Walk the requesters in priority order from ptr_i; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((int'(ptr_i) + k) % N_REQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/sum_arbiter.sv
// Round-robin arbiter sharing one combinational adder between N_REQ
// iterative units. A requester may lock the adder for a multi-cycle
// sequence; the lock is bounded to MAX_LOCK consecutive grant cycles
// (MAX_LOCK >= 2) and overruns are flagged in the sticky lock_err_o.
module sum_arbiter
  import sum_arbiter_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_LOCK = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ-1:0]   lock_i,
  input  logic [N_REQ*WIDTH-1:0] a_in_i,
  input  logic [N_REQ*WIDTH-1:0] b_in_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [WIDTH-1:0]   sum_out_o,
  output logic [WIDTH-1:0]   sum_in_a_o,
  output logic [WIDTH-1:0]   sum_in_b_o,
  input  logic [WIDTH-1:0]   sum_result_i,
  output logic               busy_o,
  output logic [N_REQ-1:0]   lock_err_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [N_REQ-1:0]   lock_err_q, lock_err_d;

  logic [N_REQ-1:0]   pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;

  logic [N_REQ-1:0]   gnt;
  logic               sel_valid;
  logic [PTR_W-1:0]   sel_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // State register; reset may arrive at any time, including mid-lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      lock_err_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      lock_err_q <= lock_err_d;
    end
  end

  // Grant selection and next state. lock_cnt_q holds the number of grant
  // cycles the owner has already had, so the current cycle is grant number
  // lock_cnt_q+1 and the forced release happens on the MAX_LOCK-th grant.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    lock_err_d = lock_err_q;
    gnt        = '0;
    sel_valid  = 1'b0;
    sel_idx    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt       = pick_gnt;
          sel_valid = 1'b1;
          sel_idx   = pick_idx;
          ptr_d     = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
          if (lock_i[pick_idx]) begin
            state_d    = ST_LOCKED;
            owner_d    = pick_idx;
            lock_cnt_d = CNT_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (req_i[owner_q]) begin
          gnt[owner_q] = 1'b1;
          sel_valid    = 1'b1;
          sel_idx      = owner_q;
        end
        if (!req_i[owner_q] || !lock_i[owner_q]) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
        end else if (lock_cnt_q >= CNT_W'(MAX_LOCK - 1)) begin
          state_d             = ST_IDLE;
          lock_cnt_d          = '0;
          lock_err_d[owner_q] = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand mux into the shared adder; idle adder inputs are held at zero.
  always_comb begin
    sum_in_a_o = '0;
    sum_in_b_o = '0;
    if (sel_valid) begin
      sum_in_a_o = a_in_i[int'(sel_idx)*WIDTH +: WIDTH];
      sum_in_b_o = b_in_i[int'(sel_idx)*WIDTH +: WIDTH];
    end
  end

  // Grants are suppressed while reset is held so they drop immediately.
  assign gnt_o      = gnt & {N_REQ{rst_ni}};
  assign sum_out_o  = sum_result_i;
  assign busy_o     = (state_q == ST_LOCKED);
  assign lock_err_o = lock_err_q;

endmodule : sum_arbiter

// File: tb/tb_sum_arbiter.sv
// Scoreboard bench for sum_arbiter: the driver computes each cycle's
// expected outputs from a behavioural model and queues them; a monitor on
// the falling edge pops and compares against the DUT.
module tb_sum_arbiter;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int ML = 5;

  typedef struct {
    logic [N-1:0] gnt;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic [W-1:0] sum;
    logic         busy;
    logic [N-1:0] err;
  } exp_t;

  logic           clk = 1'b0;
  logic           rstN = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   lock = '0;
  logic [N*W-1:0] aFlat = '0;
  logic [N*W-1:0] bFlat = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   sumOut;
  logic [W-1:0]   sumInA;
  logic [W-1:0]   sumInB;
  logic [W-1:0]   sumResult;
  logic           busy;
  logic [N-1:0]   lockErr;

  exp_t sbQ[$];
  int   nChecks = 0;
  int   nFail = 0;

  // Behavioural model state: lock held or not, rotating priority start,
  // owner, grants already given to the owner, sticky error flags.
  bit           mLocked = 1'b0;
  int           mPtr = 0;
  int           mOwner = 0;
  int           mGrants = 0;
  logic [N-1:0] mErr = '0;

  sum_arbiter #(
    .N_REQ    (N),
    .WIDTH    (W),
    .MAX_LOCK (ML)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .req_i        (req),
    .lock_i       (lock),
    .a_in_i       (aFlat),
    .b_in_i       (bFlat),
    .gnt_o        (gnt),
    .sum_out_o    (sumOut),
    .sum_in_a_o   (sumInA),
    .sum_in_b_o   (sumInB),
    .sum_result_i (sumResult),
    .busy_o       (busy),
    .lock_err_o   (lockErr)
  );

  // The shared adder: wraps modulo 2^W.
  assign sumResult = sumInA + sumInB;

  always #5 clk = ~clk;

  function automatic int firstReq(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*W-1:0] packOps(input logic [W-1:0] x0, input logic [W-1:0] x1,
                                             input logic [W-1:0] x2);
    return {x2, x1, x0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue the
  // expected outputs for that cycle, then advance the model.
  task automatic applyStimulus(input logic r_n, input logic [N-1:0] r, input logic [N-1:0] l,
                               input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    exp_t e;
    int   w;
    @(posedge clk);
    #1;
    rstN  = r_n;
    req   = r;
    lock  = l;
    aFlat = a;
    bFlat = b;
    e.gnt  = '0;
    e.busy = 1'b0;
    w      = -1;
    if (!r_n) begin
      mLocked = 1'b0;
      mPtr    = 0;
      mGrants = 0;
      mErr    = '0;
      e.err   = '0;
      w       = firstReq(r, 0);
    end else if (!mLocked) begin
      e.err = mErr;
      w     = firstReq(r, mPtr);
      if (w >= 0) begin
        e.gnt[w] = 1'b1;
        mPtr     = (w + 1) % N;
        if (l[w]) begin
          mLocked = 1'b1;
          mOwner  = w;
          mGrants = 1;
        end
      end
    end else begin
      e.err  = mErr;
      e.busy = 1'b1;
      if (r[mOwner]) begin
        w             = mOwner;
        e.gnt[mOwner] = 1'b1;
      end
      if (!r[mOwner] || !l[mOwner]) begin
        mLocked = 1'b0;
      end else if (mGrants + 1 == ML) begin
        mLocked      = 1'b0;
        mErr[mOwner] = 1'b1;
      end else begin
        mGrants++;
      end
    end
    e.opA = (w >= 0) ? a[w*W +: W] : '0;
    e.opB = (w >= 0) ? b[w*W +: W] : '0;
    e.sum = e.opA + e.opB;
    sbQ.push_back(e);
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      exp_t e;
      e = sbQ.pop_front();
      checkOutput("gnt", 32'(gnt), 32'(e.gnt));
      checkOutput("sum_in_a", 32'(sumInA), 32'(e.opA));
      checkOutput("sum_in_b", 32'(sumInB), 32'(e.opB));
      checkOutput("sum_out", 32'(sumOut), 32'(e.sum));
      checkOutput("busy", 32'(busy), 32'(e.busy));
      checkOutput("lock_err", 32'(lockErr), 32'(e.err));
    end
  end

  initial begin
    logic [N*W-1:0] opsA;
    logic [N*W-1:0] opsB;
    logic [N-1:0]   rq;
    logic [N-1:0]   lk;

    opsA = packOps(16'd27, 16'd100, 16'd5);
    opsB = packOps(16'd37, 16'd200, 16'd7);

    // Reset state, then a single requester with 27 + 37.
    applyStimulus(1'b0, 3'b001, 3'b000, opsA, opsB);
    applyStimulus(1'b0, 3'b000, 3'b000, opsA, opsB);
    applyStimulus(1'b1, 3'b001, 3'b000, opsA, opsB);

    // Fairness: two requesters held from reset alternate.
    applyStimulus(1'b0, 3'b000, 3'b000, opsA, opsB);
    repeat (4) applyStimulus(1'b1, 3'b011, 3'b000, opsA, opsB);

    // Voluntary lock release after five grant cycles.
    applyStimulus(1'b0, 3'b000, 3'b000, opsA, opsB);
    repeat (4) applyStimulus(1'b1, 3'b011, 3'b001, opsA, opsB);
    applyStimulus(1'b1, 3'b011, 3'b000, opsA, opsB);
    applyStimulus(1'b1, 3'b011, 3'b000, opsA, opsB);

    // Lock timeout: forced release after ML grants, sticky error.
    applyStimulus(1'b0, 3'b000, 3'b000, opsA, opsB);
    repeat (10) applyStimulus(1'b1, 3'b011, 3'b001, opsA, opsB);

    // Adder overflow wraps.
    applyStimulus(1'b0, 3'b000, 3'b000, opsA, opsB);
    applyStimulus(1'b1, 3'b010, 3'b000, packOps(16'd1, 16'hFFFF, 16'd3),
                  packOps(16'd1, 16'd2, 16'd4));

    // Reset in the third cycle of a locked sequence.
    applyStimulus(1'b0, 3'b000, 3'b000, opsA, opsB);
    applyStimulus(1'b1, 3'b011, 3'b001, opsA, opsB);
    applyStimulus(1'b1, 3'b011, 3'b001, opsA, opsB);
    applyStimulus(1'b0, 3'b011, 3'b001, opsA, opsB);
    applyStimulus(1'b1, 3'b011, 3'b000, opsA, opsB);

    // Randomised traffic with lock-heavy patterns and occasional resets.
    rq = '0;
    lk = '0;
    for (int i = 0; i < 400; i++) begin
      opsA = (N*W)'({$urandom(), $urandom()});
      opsB = (N*W)'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) rq = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 4) == 0) lk = N'($urandom_range(0, (1 << N) - 1));
      applyStimulus(($urandom_range(0, 63) != 0), rq, lk, opsA, opsB);
    end

    applyStimulus(1'b1, 3'b000, 3'b000, opsA, opsB);
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule : tb_sum_arbiter
